output_frame_packer: RTL and testbench

- Parametrised successor to the NPU output stage.
- Takes interior-pixel results from the NPU output FIFO in raster order and inserts a constant fill value for border pixels.
- Packs pixels into WORD_W-bit words and writes them to the output frame RAM via a registered write port.
- Handles back-to-back frames under host start/done control; the RAM read-back mux stays outside this block.

---
 rtl/output_frame_packer_if.sv | 24 ++
 rtl/output_frame_packer.sv | 142 ++++++++++++++
 tb/tb_output_frame_packer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/output_frame_packer_if.sv
// FIFO-read and RAM-write bundle of the output frame packer.
// The packer takes the slave view; the FIFO/RAM side takes the master view.
interface output_frame_packer_if #(
  parameter int FIFO_W = 32,
  parameter int WORD_W = 64,
  parameter int ADDR_W = 16
);
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WORD_W-1:0] ram_wdata;

  modport master (
    output fifo_empty, fifo_data,
    input  fifo_rd_en, ram_we, ram_waddr, ram_wdata
  );

  modport slave (
    input  fifo_empty, fifo_data,
    output fifo_rd_en, ram_we, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/output_frame_packer.sv
// Walks the frame in raster order, fills border pixels with FILL, pops interior
// pixels from a first-word-fall-through FIFO and writes packed words to RAM.
module output_frame_packer #(
  parameter int              IMG_W  = 640,
  parameter int              IMG_H  = 480,
  parameter int              BORDER = 1,
  parameter int              PIX_W  = 8,
  parameter int              WORD_W = 64,
  parameter int              FIFO_W = 32,
  parameter int              ADDR_W = 16,
  parameter logic [PIX_W-1:0] FILL  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output_frame_packer_if.slave bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 extra_data
);

  localparam int LANES = WORD_W / PIX_W;
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);
  localparam logic [LW-1:0]     L_LAST    = LW'(LANES - 1);
  localparam logic [WORD_W-1:0] FILL_WORD = {LANES{FILL}};

  // FLUSH is the one cycle in which the final word write is on the RAM port.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [LW-1:0]       lane_q;
  logic [ADDR_W-1:0]   widx_q;
  logic [WORD_W-1:0]   acc_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_waddr_q;
  logic [WORD_W-1:0]   ram_wdata_q;
  logic                extra_q;

  logic [FIFO_W-1:0]   fifo_head;
  logic                unused_fifo_bits;
  logic                border;
  logic                accept;
  logic                last_pix;
  logic                launch;
  logic                start_frame;
  logic [PIX_W-1:0]    pix;
  logic [WORD_W-1:0]   word_next;

  assign fifo_head        = bus.fifo_data;
  assign unused_fifo_bits = ^fifo_head;

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    border = (int'(x_q) < BORDER) || (int'(x_q) >= IMG_W - BORDER) ||
             (int'(y_q) < BORDER) || (int'(y_q) >= IMG_H - BORDER);
    accept      = (state_q == S_RUN) && (border || !bus.fifo_empty);
    pix         = border ? FILL : fifo_head[PIX_W-1:0];
    last_pix    = (x_q == X_LAST) && (y_q == Y_LAST);
    launch      = accept && ((lane_q == L_LAST) || last_pix);
    start_frame = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    word_next   = acc_q;
    word_next[lane_q*PIX_W +: PIX_W] = pix;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE,
      S_DONE:  if (start)              state_d = S_RUN;
      S_RUN:   if (accept && last_pix) state_d = S_FLUSH;
      S_FLUSH:                         state_d = S_DONE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      lane_q      <= '0;
      widx_q      <= '0;
      acc_q       <= FILL_WORD;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      extra_q     <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      if (((state_q == S_IDLE) || (state_q == S_DONE)) && !bus.fifo_empty)
        extra_q <= 1'b1;

      if (start_frame) begin
        x_q    <= '0;
        y_q    <= '0;
        lane_q <= '0;
        widx_q <= '0;
        acc_q  <= FILL_WORD;
      end else if (accept) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
        // Refilling with FILL_WORD leaves FILL in unused lanes of a short final word.
        if (launch) begin
          lane_q      <= '0;
          acc_q       <= FILL_WORD;
          ram_we_q    <= 1'b1;
          ram_waddr_q <= widx_q;
          ram_wdata_q <= word_next;
          widx_q      <= widx_q + 1'b1;
        end else begin
          lane_q <= lane_q + 1'b1;
          acc_q  <= word_next;
        end
      end
    end
  end

  assign bus.fifo_rd_en = (state_q == S_RUN) && !border && !bus.fifo_empty;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_waddr  = ram_waddr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign busy           = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign frame_done     = (state_q == S_DONE);
  assign extra_data     = extra_q;

endmodule

// File: tb/tb_output_frame_packer.sv
// Randomised bench for output_frame_packer on an 8x4 frame with a 1-pixel border,
// checked every cycle against a linear-position reference model.
`timescale 1ns/1ps
module tb_output_frame_packer;
  localparam int IMG_W = 8, IMG_H = 4, BORDER = 1;
  localparam int PIX_W = 8, WORD_W = 64, FIFO_W = 32, ADDR_W = 16;
  localparam logic [7:0] FILL = 8'h00;
  localparam int LANES = WORD_W / PIX_W;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NINT  = (IMG_W - 2*BORDER) * (IMG_H - 2*BORDER);

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic busy, frame_done, extra_data;

  int vectors = 0, miscompares = 0;

  // FIFO model: array plus read/write pointers; gate forces an empty view.
  logic [FIFO_W-1:0] fifo_mem [256];
  int   rd_ptr = 0;
  int   wr_cnt = 0;
  logic gate   = 1'b0;

  typedef struct { logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] data; } wr_t;
  wr_t wlog [$];

  output_frame_packer_if #(.FIFO_W(FIFO_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  output_frame_packer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER(BORDER), .PIX_W(PIX_W),
    .WORD_W(WORD_W), .FIFO_W(FIFO_W), .ADDR_W(ADDR_W), .FILL(FILL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done), .extra_data(extra_data)
  );

  assign bus.fifo_empty = (rd_ptr >= wr_cnt) || gate;
  assign bus.fifo_data  = fifo_mem[rd_ptr];

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)             rd_ptr <= 0;
    else if (bus.fifo_rd_en)  rd_ptr <= rd_ptr + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_border(input int q);
    int x, y;
    x = q % IMG_W;
    y = q / IMG_W;
    return (x < BORDER) || (x >= IMG_W - BORDER) || (y < BORDER) || (y >= IMG_H - BORDER);
  endfunction

  // Word a of a frame whose interior pixels start at FIFO entry base.
  function automatic logic [63:0] exp_word(input int a, input int base);
    logic [63:0] w;
    logic [7:0]  p;
    int q;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      q = a*LANES + k;
      if (q >= NPIX || is_border(q)) p = FILL;
      else p = fifo_mem[base + (q/IMG_W - BORDER)*(IMG_W - 2*BORDER) + (q%IMG_W - BORDER)][7:0];
      w[k*PIX_W +: PIX_W] = p;
    end
    return w;
  endfunction

  // Reference model: frame phase, linear pixel position, pending write.
  typedef enum {M_IDLE, M_RUN, M_TAIL, M_DONE} mph_t;
  mph_t m_ph = M_IDLE;
  int   m_p = 0, m_base = 0, m_wa = 0;
  bit   m_we = 1'b0, m_extra = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_fifo_rd_en", bus.fifo_rd_en, 0);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_ram_waddr", bus.ram_waddr, 0);
      check("rst_ram_wdata", bus.ram_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_extra_data", extra_data, 0);
      m_ph = M_IDLE; m_we = 1'b0; m_extra = 1'b0;
    end else begin : cmp
      logic exp_rd;
      exp_rd = (m_ph == M_RUN) && !is_border(m_p) && !bus.fifo_empty;
      check("busy", busy, (m_ph == M_RUN) || (m_ph == M_TAIL));
      check("frame_done", frame_done, m_ph == M_DONE);
      check("extra_data", extra_data, m_extra);
      check("fifo_rd_en", bus.fifo_rd_en, exp_rd);
      check("ram_we", bus.ram_we, m_we);
      if (m_we) begin
        check("ram_waddr", bus.ram_waddr, m_wa);
        check("ram_wdata", bus.ram_wdata, exp_word(m_wa, m_base));
      end
      if (bus.ram_we) wlog.push_back('{bus.ram_waddr, bus.ram_wdata});

      if (((m_ph == M_IDLE) || (m_ph == M_DONE)) && !bus.fifo_empty) m_extra = 1'b1;
      m_we = 1'b0;
      case (m_ph)
        M_IDLE, M_DONE: if (start) begin m_ph = M_RUN; m_p = 0; m_base = rd_ptr; end
        M_RUN: if (is_border(m_p) || !bus.fifo_empty) begin
          if ((m_p % LANES == LANES-1) || (m_p == NPIX-1)) begin m_we = 1'b1; m_wa = m_p / LANES; end
          if (m_p == NPIX-1) m_ph = M_TAIL;
          else m_p++;
        end
        M_TAIL: m_ph = M_DONE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  task automatic load_pixels(input bit rnd);
    logic [31:0] r;
    for (int i = 0; i < NINT; i++) begin
      r = $urandom;
      fifo_mem[wr_cnt + i] = {r[31:8], rnd ? r[7:0] : 8'(i + 1)};
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: FIFO never starves; 1: 5-cycle stall at (1,1) plus a start in RUN;
  // 2: random starvation and random starts while busy.
  task automatic run_frame(input int mode, output int bc);
    load_pixels(mode == 2);
    pulse_start();
    check("done_drop", frame_done, 0);
    gate   = (mode == 1);
    wr_cnt = wr_cnt + NINT;
    bc = 0;
    for (int c = 0; c < 400 && !frame_done; c++) begin
      if (busy) bc++;
      case (mode)
        1: begin gate = (c < 14); start = (c == 20); end
        2: begin gate = ($urandom_range(0, 3) == 0); start = busy && ($urandom_range(0, 15) == 0); end
        default: gate = 1'b0;
      endcase
      @(posedge clk); #1;
    end
    gate = 1'b0; start = 1'b0;
    check("frame_finished", frame_done, 1);
  endtask

  task automatic check_wr(input string name, input int i, input logic [15:0] a, input logic [63:0] d);
    if (wlog.size() > i) begin
      check({name, "_addr"}, wlog[i].addr, a);
      check({name, "_data"}, wlog[i].data, d);
    end else begin
      check({name, "_present"}, wlog.size(), i + 1);
    end
  endtask

  initial begin
    int bc, pops0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Frame A: clean stream of 1..12.
    wlog.delete(); pops0 = rd_ptr;
    run_frame(0, bc);
    check("a_busy_cycles", bc, 33);
    check("a_pops", rd_ptr - pops0, 12);
    check("a_nwrites", wlog.size(), 4);
    check_wr("a_w0", 0, 16'd0, 64'h0);
    check_wr("a_w1", 1, 16'd1, 64'h0006050403020100);
    check_wr("a_w2", 2, 16'd2, 64'h000C0B0A09080700);
    check_wr("a_w3", 3, 16'd3, 64'h0);

    // Frame B: back-to-back from DONE, stalled at (1,1), stray start in RUN.
    check("b_done_held", frame_done, 1);
    wlog.delete(); pops0 = rd_ptr;
    run_frame(1, bc);
    check("b_busy_cycles", bc, 38);
    check("b_pops", rd_ptr - pops0, 12);
    check("b_nwrites", wlog.size(), 4);
    check_wr("b_w0", 0, 16'd0, 64'h0);
    check_wr("b_w1", 1, 16'd1, 64'h0006050403020100);
    check_wr("b_w2", 2, 16'd2, 64'h000C0B0A09080700);

    for (int f = 0; f < 6; f++) begin
      wlog.delete(); pops0 = rd_ptr;
      run_frame(2, bc);
      check("r_nwrites", wlog.size(), 4);
      check("r_pops", rd_ptr - pops0, 12);
    end

    // A word arriving in DONE flags extra_data, is not popped and is not written.
    wlog.delete();
    @(posedge clk); #1;
    fifo_mem[wr_cnt] = 32'h1234_5677;
    wr_cnt = wr_cnt + 1;
    pops0 = rd_ptr;
    repeat (3) begin @(posedge clk); #1; end
    check("extra_set", extra_data, 1);
    check("extra_no_pop", rd_ptr - pops0, 0);
    check("extra_no_write", wlog.size(), 0);
    run_frame(0, bc);
    check("extra_held", extra_data, 1);
    check_wr("x_w1", 1, 16'd1, 64'h0005040302017700);

    // Reset mid-frame after 10 pops.
    load_pixels(1'b1);
    pulse_start();
    wr_cnt = wr_cnt + NINT;
    for (int c = 0; c < 100 && rd_ptr < 10; c++) begin @(posedge clk); #1; end
    check("mid_pops_reached", rd_ptr >= 10, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_fifo_rd_en", bus.fifo_rd_en, 0);
    check("mid_rst_ram_we", bus.ram_we, 0);
    check("mid_rst_ram_waddr", bus.ram_waddr, 0);
    check("mid_rst_ram_wdata", bus.ram_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_extra_data", extra_data, 0);
    wr_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wlog.delete();
    run_frame(0, bc);
    check("p_busy_cycles", bc, 33);
    check("p_nwrites", wlog.size(), 4);
    check_wr("p_w0", 0, 16'd0, 64'h0);
    check_wr("p_w1", 1, 16'd1, 64'h0006050403020100);
    check("p_extra_clear", extra_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
